// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - UART 8N1 byte receiver with 16x oversampling and majority vote
module uart_byte_rx #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] baud_set,
    input  logic       uart_rx,
    output logic [7:0] Data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Terminal counts (divisor - 1) of the oversample divider per baud setting
    localparam logic [15:0] LIM_9600   = 16'(CLK_FREQ / (9600 * 16) - 1);
    localparam logic [15:0] LIM_19200  = 16'(CLK_FREQ / (19200 * 16) - 1);
    localparam logic [15:0] LIM_38400  = 16'(CLK_FREQ / (38400 * 16) - 1);
    localparam logic [15:0] LIM_57600  = 16'(CLK_FREQ / (57600 * 16) - 1);
    localparam logic [15:0] LIM_115200 = 16'(CLK_FREQ / (115200 * 16) - 1);

    logic        rx_s1, rx_s2, rx_s3;
    logic        start_edge;
    logic [1:0]  state;
    logic [15:0] div_lim;
    logic [15:0] div_cnt;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  smp;
    logic [7:0]  shreg;
    logic        tick;
    logic        mid;
    logic        bit_end;
    logic        vote;
    logic [15:0] lim_sel;

    // Baud decode; unused encodings fall back to 9600
    always_comb begin
        lim_sel = LIM_9600;
        case (baud_set)
            3'd1:    lim_sel = LIM_19200;
            3'd2:    lim_sel = LIM_38400;
            3'd3:    lim_sel = LIM_57600;
            3'd4:    lim_sel = LIM_115200;
            default: lim_sel = LIM_9600;
        endcase
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = rx_s3 & ~rx_s2;
    assign tick       = (state != IDLE) && (div_cnt == div_lim);
    assign mid        = tick && (tick_cnt == 4'd8);
    assign bit_end    = tick && (tick_cnt == 4'd15);
    // 2-of-3 vote over the tick-6 and tick-7 samples and the live tick-8 sample
    assign vote       = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);

    // Oversample divider and per-bit tick counter; both idle outside a frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_lim  <= 16'd0;
            div_cnt  <= 16'd0;
            tick_cnt <= 4'd0;
            smp      <= 2'b00;
        end else if (state == IDLE) begin
            div_cnt  <= 16'd0;
            tick_cnt <= 4'd0;
            if (start_edge) begin
                div_lim <= lim_sel;
            end
        end else begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'd6) smp[0] <= rx_s2;
                if (tick_cnt == 4'd7) smp[1] <= rx_s2;
            end
        end
    end

    // Frame sequencing, data shifting and the one-cycle completion strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            Data      <= 8'd0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    if (start_edge) state <= START;
                end
                START: begin
                    if (mid && vote) state <= IDLE;
                    else if (bit_end) state <= DATA;
                end
                DATA: begin
                    if (mid) shreg <= {vote, shreg[7:1]};
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    // Hand off at mid stop bit so a slightly fast sender's next start is not missed
                    if (mid) begin
                        Data      <= shreg;
                        rx_done   <= 1'b1;
                        frame_err <= ~vote;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - randomized scoreboard bench for uart_byte_rx
module tb_uart_byte_rx;

    // 16 * 115200 * 2: every baud divisor is exact, keeping frames short
    localparam int CLK_FREQ = 3686400;
    localparam int DIV4     = CLK_FREQ / (115200 * 16);

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic       uart_rx = 1'b1;
    logic [7:0] Data;
    logic       rx_done;
    logic       frame_err;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   done_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always #10 Clk = ~Clk;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .baud_set  (baud_set),
        .uart_rx   (uart_rx),
        .Data      (Data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int bit_clks(input logic [2:0] bs);
        int rate;
        case (bs)
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            default: rate = 9600;
        endcase
        return CLK_FREQ / rate;
    endfunction

    // Monitor: pops the scoreboard on every completion strobe
    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n) begin
            if (prev_done) check("done_width", int'(rx_done), 0);
            if (!rx_done && frame_err) check("ferr_without_done", 1, 0);
            if (rx_done) begin
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", int'(Data), int'(e.data));
                    check("frame_err", int'(frame_err), int'(e.ferr));
                end
            end
        end
        prev_done <= rx_done;
    end

    // Bit-level line waveform: frame bits at a scaled period, optional forced-low window
    task automatic drive_frame(input logic [7:0] b, input logic [2:0] bs, input logic stop,
                               input int permille, input int g_at, input int g_len,
                               input int max_clks);
        logic [9:0] bits;
        int per;
        int n;
        int bi;
        logic lvl;
        bits = {stop, b, 1'b0};
        per  = bit_clks(bs) * permille;
        n    = (10 * per) / 1000;
        baud_set = bs;
        for (int c = 0; c < n && c < max_clks; c++) begin
            @(negedge Clk);
            bi  = (c * 1000) / per;
            lvl = bits[bi];
            if (c >= g_at && c < g_at + g_len) lvl = 1'b0;
            uart_rx = lvl;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [2:0] bs, input logic stop,
                        input int permille);
        exp_t e;
        e.data = b;
        e.ferr = ~stop;
        exp_q.push_back(e);
        drive_frame(b, bs, stop, permille, -1, 0, 1 << 30);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge Clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8000 && exp_q.size() != 0; i++) @(negedge Clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int diff;
        logic [7:0] rb;
        logic [2:0] rbs;
        logic rstop;

        repeat (3) @(negedge Clk);
        check("reset_data", int'(Data), 0);
        check("reset_done", int'(rx_done), 0);
        check("reset_ferr", int'(frame_err), 0);
        Reset_n = 1'b1;
        idle(20);

        send(8'h55, 3'd4, 1'b1, 1000);
        idle(8);
        drain("drain_55");

        // Reset in the middle of a frame
        drive_frame(8'hA5, 3'd4, 1'b1, 1000, -1, 0, 150);
        Reset_n = 1'b0;
        #1;
        check("midrst_data", int'(Data), 0);
        check("midrst_done", int'(rx_done), 0);
        check("midrst_ferr", int'(frame_err), 0);
        idle(5);
        Reset_n = 1'b1;
        idle(20);
        send(8'h3C, 3'd4, 1'b1, 1000);
        idle(8);
        drain("drain_3c");

        for (int bs = 0; bs < 4; bs++) begin
            send(8'h01, 3'(bs), 1'b1, 1000);
            idle(4);
            send(8'h80, 3'(bs), 1'b1, 1000);
            idle(4);
        end
        send(8'h01, 3'd7, 1'b1, 1000);
        idle(4);
        drain("drain_bauds");

        // Back-to-back frames with no idle between stop and start
        send(8'hA3, 3'd0, 1'b1, 1000);
        send(8'h0F, 3'd0, 1'b1, 1000);
        idle(8);
        drain("drain_b2b");
        diff = done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2];
        check("b2b_gap", int'(diff >= 10 * bit_clks(3'd0) - 4 && diff <= 10 * bit_clks(3'd0) + 4), 1);

        // False start: low for three ticks only
        n0 = done_cyc.size();
        baud_set = 3'd4;
        @(negedge Clk);
        uart_rx = 1'b0;
        repeat (3 * DIV4) @(negedge Clk);
        idle(400);
        check("false_start_done", done_cyc.size() - n0, 0);
        check("false_start_data", int'(Data), 8'h0F);
        send(8'h5A, 3'd4, 1'b1, 1000);
        idle(8);
        drain("drain_5a");

        send(8'hFF, 3'd4, 1'b0, 1000);
        idle(64);
        drain("drain_stop_low");

        // Break: line held low for 20 bit times
        n0 = done_cyc.size();
        begin
            exp_t e;
            e.data = 8'h00;
            e.ferr = 1'b1;
            exp_q.push_back(e);
        end
        @(negedge Clk);
        uart_rx = 1'b0;
        repeat (20 * bit_clks(3'd4)) @(negedge Clk);
        idle(64);
        check("break_count", done_cyc.size() - n0, 1);
        drain("drain_break");
        send(8'h42, 3'd4, 1'b1, 1000);
        idle(8);
        drain("drain_42");

        send(8'h96, 3'd4, 1'b1, 1020);
        idle(8);
        send(8'h96, 3'd4, 1'b1, 980);
        idle(8);
        drain("drain_tol");

        // Single-tick low glitch aligned to the tick-7 sample of D3
        begin
            exp_t e;
            e.data = 8'hFF;
            e.ferr = 1'b0;
            exp_q.push_back(e);
        end
        drive_frame(8'hFF, 3'd4, 1'b1, 1000, (16 * 4 + 8) * DIV4, DIV4, 1 << 30);
        idle(8);
        drain("drain_glitch");

        for (int i = 0; i < 6; i++) begin
            rb    = 8'($urandom);
            rbs   = 3'($urandom_range(1, 4));
            rstop = ($urandom_range(0, 3) != 0);
            send(rb, rbs, rstop, 1000);
            idle($urandom_range(2, 12));
        end
        idle(100);
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Receives one UART frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous `uart_rx` pin.
It presents the byte on `Data` with a one-cycle `rx_done` strobe.
It is the receive-side counterpart of the team's byte transmitter and uses the same `baud_set` encoding.
It sits between the board RX pin and user logic such as loopback, command parsing or FIFO write.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; used to derive the oversample divisor.

Ports:
Clk  input  1  system clock.
Reset_n  input  1  asynchronous, active-low reset.
baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5..7 are treated as 9600.
uart_rx  input  1  serial line; asynchronous to Clk; idles high.
Data  output  8  last received byte; held until the next completed frame.
rx_done  output  1  one-Clk pulse when a frame completes.
frame_err  output  1  valid only with `rx_done`; 1 = stop bit sampled low.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low on Reset_n. All other logic is synchronous to Clk.
  - Reset values: Data=0, rx_done=0, frame_err=0, FSM=IDLE, all counters 0.
  - Synchronizer flops reset to 1 (line idle).
- Input conditioning:
  - `uart_rx` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - A start is a synchronized 1->0 transition seen while in IDLE.
- Oversample tick:
  - Divisor DIV = CLK_FREQ/(baud*16), integer-truncated. At 50 MHz: 325, 162, 81, 54, 27 for settings 0..4.
  - The tick counter runs only outside IDLE and restarts at 0 on the start edge.
  - `baud_set` is latched at the start edge; changes mid-frame have no effect until the next frame.
- Frame timing:
  - The frame is 160 ticks: bit index b = 0..9 (0 = start, 1..8 = D0..D7, 9 = stop), 16 ticks per bit.
  - Within each bit, the synchronized line is sampled at ticks 6, 7 and 8; the bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the start edge.
  - START: after the tick-8 vote, if the majority is 1 (glitch), go to IDLE with no `rx_done` and no Data change. Otherwise continue to DATA at the end of the bit.
  - DATA: shift the voted bits into a shift register LSB first, for 8 bits, then go to STOP.
  - STOP: in the cycle after the tick-8 vote, load Data from the shift register, pulse `rx_done` for exactly one Clk, drive `frame_err` = ~stop_vote for that same cycle, then return to IDLE.
  - The FSM does not wait for the remaining half stop bit. This tolerates senders running slightly fast, and allows back-to-back frames.
- Output rules:
  - `frame_err` is 0 whenever `rx_done` is 0.
  - Data updates even when `frame_err` = 1.
- Latency: `rx_done` rises 9.5 bit times + 3..5 Clk after the falling edge at the pin, plus at most one tick of edge-alignment error.
- Boundary conditions:
  - Break (line held low): the frame completes with `frame_err` = 1 and Data = 0x00. No further frame starts until the line returns high and falls again (edge-triggered).
  - Start edge arriving during the STOP handoff cycle: it is detected in IDLE on the next cycle. Edges are not lost because the edge flop is registered.
  - Reset mid-frame: immediate return to the reset values; no `rx_done` is emitted.
  - Line noise during data bits: a single-tick glitch at a sample point is rejected by the majority vote.

Test Plan:
- Reset: assert Reset_n=0 mid-frame -> Data=0x00, rx_done=0, frame_err=0 immediately. After release, the next valid frame 0x3C at baud_set=4 -> Data=0x3C.
- Basic frame: baud_set=4, drive 0x55 at 115200 (434 Clk/bit) -> one `rx_done` pulse exactly 1 Clk wide, Data=0x55, frame_err=0. Repeat with 0x01 and 0x80 at baud_set 0..3, each setting at its own bit period -> correct byte each time.
- Back-to-back: baud_set=0, send 0xA3 then 0x0F with zero idle between stop and next start -> two `rx_done` pulses ~10 bit times apart, Data=0xA3 then 0x0F.
- False start: baud_set=4, pull the line low for 3 ticks (81 Clk), then high -> no `rx_done`, Data unchanged, FSM back in IDLE; a following 0x5A is received correctly.
- Frame error and break:
  - Send 0xFF with the stop bit low -> rx_done with frame_err=1, Data=0xFF.
  - Hold the line low for 20 bit times -> exactly one rx_done (Data=0x00, frame_err=1).
  - Release high, then send 0x42 -> Data=0x42, frame_err=0.
- Clock tolerance and glitch: send 0x96 with a bit period 2% longer, then 2% shorter, than nominal -> Data=0x96 both times. Inject a 1-tick low glitch at the tick-7 point of D3 of 0xFF -> Data=0xFF.
